stream_packet_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one 32-bit valid/ready/first/last stream output among N input streams. It sits in front of a single-stream consumer, such as a processing core or serializer, and locks the grant to one requester from the winning beat until the beat flagged `last` has transferred. Payload, `first` and `last` pass through unmodified. The arbiter only decides ownership and gates the handshake.

---
 rtl/stream_packet_arbiter_if.sv | 40 ++++
 rtl/stream_packet_arbiter.sv | 135 +++++++++++++
 tb/tb_stream_packet_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_packet_arbiter_if.sv
// Stream bundle shared by the packet arbiter and whatever surrounds it:
// N request streams in (rx side), one merged stream out (tx side), plus the
// current grant status. The master side drives the requests and the
// downstream ready; the slave side is the arbiter itself.
interface stream_packet_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    // Per-port request streams
    logic [N_PORTS-1:0]        valid_rx;
    logic [N_PORTS-1:0]        ready_rx;
    logic [N_PORTS-1:0]        first_rx;
    logic [N_PORTS-1:0]        last_rx;
    logic [N_PORTS*DATA_W-1:0] payload_rx;

    // Merged output stream
    logic                      valid_tx;
    logic                      ready_tx;
    logic                      first_tx;
    logic                      last_tx;
    logic [DATA_W-1:0]         payload_tx;

    // Grant status
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;

    modport master (
        output valid_rx, first_rx, last_rx, payload_rx, ready_tx,
        input  ready_rx, valid_tx, first_tx, last_tx, payload_tx,
        input  grant_valid, grant_id
    );

    modport slave (
        input  valid_rx, first_rx, last_rx, payload_rx, ready_tx,
        output ready_rx, valid_tx, first_tx, last_tx, payload_tx,
        output grant_valid, grant_id
    );
endinterface

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter. One requester at a time owns the
// single output stream from its winning beat until a beat flagged `last`
// has transferred. The tx side is a pure combinational mux of the owning
// port: no buffering, no added beat latency. Every packet boundary costs
// exactly one IDLE cycle in which the next owner is chosen.
module stream_packet_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32
) (
    input logic                  clk,
    input logic                  rst,
    stream_packet_arbiter_if.slave bus
);
    localparam int ID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     grant_id_q;   // owner while LOCKED, last winner otherwise
    logic [ID_W-1:0]     last_grant;   // round-robin pointer: search starts one above
    logic                grant_valid_q;

    logic [ID_W-1:0]     winner;
    logic                any_valid;
    int                  idx;

    logic                sel_valid;
    logic                sel_first;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_payload;
    logic [N_PORTS-1:0]  ready_rx_d;
    logic                xfer;

    assign any_valid = |bus.valid_rx;

    // Round-robin pick: the first valid port at or after last_grant+1, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        winner = last_grant;
        idx    = 0;
        // Walk from the farthest offset down to the nearest so the closest
        // valid port (the highest priority one) is the last assignment.
        for (int off = N_PORTS; off >= 1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (bus.valid_rx[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

    // Output mux: forward the owning port verbatim while LOCKED, zeros in IDLE.
    always_comb begin
        sel_valid   = 1'b0;
        sel_first   = 1'b0;
        sel_last    = 1'b0;
        sel_payload = '0;
        if (state == LOCKED) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (grant_id_q == ID_W'(i)) begin
                    sel_valid   = bus.valid_rx[i];
                    sel_first   = bus.first_rx[i];
                    sel_last    = bus.last_rx[i];
                    sel_payload = bus.payload_rx[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Ready steering: only the owner sees the downstream ready. The handshake
    // is held off while rst is high so no beat is consumed on either side of
    // a reset cycle.
    always_comb begin
        ready_rx_d = '0;
        if (state == LOCKED && !rst) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (grant_id_q == ID_W'(i)) begin
                    ready_rx_d[i] = bus.ready_tx;
                end
            end
        end
    end

    assign xfer = sel_valid & bus.ready_tx;

    // Lock FSM: take a winner in IDLE, release after the last beat transfers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of all the others.
        if (rst) begin
            state         <= IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            last_grant    <= ID_W'(N_PORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id_q    <= winner;
                        grant_valid_q <= 1'b1;
                        state         <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Gaps in the owner's valid never release the lock;
                    // only a transferred last beat does.
                    if (xfer && sel_last) begin
                        last_grant    <= grant_id_q;
                        grant_valid_q <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    grant_valid_q <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.valid_tx    = sel_valid & ~rst;
    assign bus.first_tx    = sel_first;
    assign bus.last_tx     = sel_last;
    assign bus.payload_tx  = sel_payload;
    assign bus.ready_rx    = ready_rx_d;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed bench for stream_packet_arbiter (4 ports, 32-bit payload).
// Each table record is one clock cycle: inputs are driven after the falling
// edge, outputs are compared 1 ns later, and the rising edge then commits the
// cycle. Port i always carries payload {i[7:0], 16'h0, byte} so a wrong mux
// selection is visible in the payload. A hand-written fairness run follows.
module tb_stream_packet_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic clk;
    logic rst;

    stream_packet_arbiter_if #(.N_PORTS(N), .DATA_W(W)) bus ();

    stream_packet_arbiter #(.N_PORTS(N), .DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  first;
        logic [3:0]  last;
        logic [7:0]  pl;
        logic        rtx;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pl_of(input int port, input logic [7:0] b);
        logic [7:0] tag;
        tag = port[7:0];
        return {tag, 16'h0, b};
    endfunction

    // {valid_tx, first_tx, last_tx, grant_valid, grant_id, ready_rx, payload_tx}
    function automatic logic [63:0] pack(input logic v, input logic f, input logic l,
                                         input logic gv, input logic [1:0] gid,
                                         input logic [3:0] rdy, input logic [31:0] p);
        return {22'h0, v, f, l, gv, gid, rdy, p};
    endfunction

    function automatic logic [63:0] sample();
        return pack(bus.valid_tx, bus.first_tx, bus.last_tx, bus.grant_valid,
                    bus.grant_id, bus.ready_rx, bus.payload_tx);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic r, input logic [3:0] va,
                           input logic [3:0] fi, input logic [3:0] la, input logic [7:0] pl,
                           input logic rtx, input logic [63:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.valid = va; v.first = fi; v.last = la;
        v.pl = pl; v.rtx = rtx; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Arbiter in IDLE: everything zero, grant_id holds the previous winner.
    task automatic idle_v(input string name, input logic r, input logic [3:0] va,
                          input logic [3:0] fi, input logic [3:0] la, input logic [7:0] pl,
                          input logic rtx, input logic [1:0] gid);
        add_vec(name, r, va, fi, la, pl, rtx, pack(1'b0, 1'b0, 1'b0, 1'b0, gid, 4'b0, 32'h0));
    endtask

    // Arbiter LOCKED on gid: tx mirrors port gid.
    task automatic lock_v(input string name, input logic [3:0] va, input logic [3:0] fi,
                          input logic [3:0] la, input logic [7:0] pl, input logic rtx,
                          input logic [1:0] gid, input logic ev, input logic ef,
                          input logic el, input logic [3:0] rdy);
        add_vec(name, 1'b0, va, fi, la, pl, rtx,
                pack(ev, ef, el, 1'b1, gid, rdy, pl_of(int'(gid), pl)));
    endtask

    task automatic drive(input logic r, input logic [3:0] va, input logic [3:0] fi,
                         input logic [3:0] la, input logic [7:0] pl, input logic rtx);
        rst          = r;
        bus.valid_rx = va;
        bus.first_rx = fi;
        bus.last_rx  = la;
        bus.ready_tx = rtx;
        for (int i = 0; i < N; i++) begin
            bus.payload_rx[i*W +: W] = pl_of(i, pl);
        end
    endtask

    function automatic logic [3:0] onehot(input int p);
        logic [3:0] m;
        m = 4'b0001 << p;
        return m;
    endfunction

    initial begin
        int rr_order[6];
        int p;
        int waited;
        rr_order = '{0, 1, 2, 3, 0, 1};

        // ---- single requester: port 2, 3 beats A0..A2 ----
        idle_v("reset_state", 1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 2'd0);
        idle_v("sr_request",  1'b0, 4'b0100, 4'b0100, 4'b0000, 8'hA0, 1'b1, 2'd0);
        lock_v("sr_beat0", 4'b0100, 4'b0100, 4'b0000, 8'hA0, 1'b1, 2'd2, 1, 1, 0, 4'b0100);
        lock_v("sr_beat1", 4'b0100, 4'b0000, 4'b0000, 8'hA1, 1'b1, 2'd2, 1, 0, 0, 4'b0100);
        lock_v("sr_beat2", 4'b0100, 4'b0000, 4'b0100, 8'hA2, 1'b1, 2'd2, 1, 0, 1, 4'b0100);
        idle_v("sr_released", 1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 2'd2);

        // ---- round robin: all ports offer 2-beat packets ----
        idle_v("rr_reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 2'd2);
        for (int k = 0; k < 6; k++) begin
            p = rr_order[k];
            idle_v($sformatf("rr_bubble%0d", k), 1'b0, 4'b1111, 4'b1111, 4'b0000, 8'hB0,
                   1'b1, (k == 0) ? 2'd0 : 2'(rr_order[k-1]));
            lock_v($sformatf("rr_pkt%0d_b0", k), 4'b1111, 4'b1111, 4'b0000, 8'hB0, 1'b1,
                   2'(p), 1, 1, 0, onehot(p));
            lock_v($sformatf("rr_pkt%0d_b1", k), 4'b1111, 4'b0000, 4'b1111, 8'hB1, 1'b1,
                   2'(p), 1, 0, 1, onehot(p));
        end
        idle_v("rr_end", 1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 2'd1);

        // ---- backpressure: port 1 4 beats, ready 1,0,0,1,1,0,0,1; port 3 waits ----
        idle_v("bp_reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 2'd1);
        idle_v("bp_request", 1'b0, 4'b1010, 4'b1010, 4'b0000, 8'hC0, 1'b1, 2'd0);
        lock_v("bp_beat0",  4'b1010, 4'b1010, 4'b0000, 8'hC0, 1'b1, 2'd1, 1, 1, 0, 4'b0010);
        lock_v("bp_stall1", 4'b1010, 4'b1000, 4'b0000, 8'hC1, 1'b0, 2'd1, 1, 0, 0, 4'b0000);
        lock_v("bp_stall2", 4'b1010, 4'b1000, 4'b0000, 8'hC1, 1'b0, 2'd1, 1, 0, 0, 4'b0000);
        lock_v("bp_beat1",  4'b1010, 4'b1000, 4'b0000, 8'hC1, 1'b1, 2'd1, 1, 0, 0, 4'b0010);
        lock_v("bp_beat2",  4'b1010, 4'b1000, 4'b0000, 8'hC2, 1'b1, 2'd1, 1, 0, 0, 4'b0010);
        lock_v("bp_stall3", 4'b1010, 4'b1000, 4'b0010, 8'hC3, 1'b0, 2'd1, 1, 0, 1, 4'b0000);
        lock_v("bp_stall4", 4'b1010, 4'b1000, 4'b0010, 8'hC3, 1'b0, 2'd1, 1, 0, 1, 4'b0000);
        lock_v("bp_beat3",  4'b1010, 4'b1000, 4'b0010, 8'hC3, 1'b1, 2'd1, 1, 0, 1, 4'b0010);
        idle_v("bp_bubble", 1'b0, 4'b1000, 4'b1000, 4'b1000, 8'hD0, 1'b1, 2'd1);
        lock_v("bp_port3",  4'b1000, 4'b1000, 4'b1000, 8'hD0, 1'b1, 2'd3, 1, 1, 1, 4'b1000);
        idle_v("bp_end", 1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 2'd3);

        // ---- source gaps: port 0 stalls 3 cycles, port 1 waiting ----
        idle_v("sg_request", 1'b0, 4'b0011, 4'b0011, 4'b0000, 8'hE0, 1'b1, 2'd3);
        lock_v("sg_beat0", 4'b0011, 4'b0011, 4'b0000, 8'hE0, 1'b1, 2'd0, 1, 1, 0, 4'b0001);
        lock_v("sg_gap0",  4'b0010, 4'b0010, 4'b0000, 8'hE1, 1'b1, 2'd0, 0, 0, 0, 4'b0001);
        lock_v("sg_gap1",  4'b0010, 4'b0010, 4'b0000, 8'hE1, 1'b1, 2'd0, 0, 0, 0, 4'b0001);
        lock_v("sg_gap2",  4'b0010, 4'b0010, 4'b0000, 8'hE1, 1'b1, 2'd0, 0, 0, 0, 4'b0001);
        lock_v("sg_beat1", 4'b0011, 4'b0010, 4'b0001, 8'hE1, 1'b1, 2'd0, 1, 0, 1, 4'b0001);
        idle_v("sg_bubble", 1'b0, 4'b0010, 4'b0010, 4'b0010, 8'hF0, 1'b1, 2'd0);
        lock_v("sg_port1", 4'b0010, 4'b0010, 4'b0010, 8'hF0, 1'b1, 2'd1, 1, 1, 1, 4'b0010);

        // ---- wrap and single-beat packets ----
        idle_v("wr_req3", 1'b0, 4'b1000, 4'b1000, 4'b1000, 8'hA5, 1'b1, 2'd1);
        lock_v("wr_port3a", 4'b1000, 4'b1000, 4'b1000, 8'hA5, 1'b1, 2'd3, 1, 1, 1, 4'b1000);
        idle_v("wr_both", 1'b0, 4'b1001, 4'b1001, 4'b1001, 8'hB5, 1'b1, 2'd3);
        lock_v("wr_port0", 4'b1001, 4'b1001, 4'b1001, 8'hB5, 1'b1, 2'd0, 1, 1, 1, 4'b0001);
        idle_v("wr_bubble", 1'b0, 4'b1000, 4'b1000, 4'b1000, 8'hC5, 1'b1, 2'd0);
        lock_v("wr_port3b", 4'b1000, 4'b1000, 4'b1000, 8'hC5, 1'b1, 2'd3, 1, 1, 1, 4'b1000);
        idle_v("wr_end", 1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 2'd3);

        // ---- reset mid-packet: port 0, reset on beat 2 ----
        idle_v("mr_request", 1'b0, 4'b0001, 4'b0001, 4'b0000, 8'h50, 1'b1, 2'd3);
        lock_v("mr_beat0", 4'b0001, 4'b0001, 4'b0000, 8'h50, 1'b1, 2'd0, 1, 1, 0, 4'b0001);
        lock_v("mr_beat1", 4'b0001, 4'b0000, 4'b0000, 8'h51, 1'b1, 2'd0, 1, 0, 0, 4'b0001);
        add_vec("mr_rst_cycle", 1'b1, 4'b0100, 4'b0100, 4'b0000, 8'h52, 1'b0,
                pack(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, pl_of(0, 8'h52)));
        idle_v("mr_after_rst", 1'b0, 4'b0101, 4'b0101, 4'b0000, 8'h60, 1'b1, 2'd0);
        lock_v("mr_port0_prio", 4'b0101, 4'b0101, 4'b0000, 8'h60, 1'b1, 2'd0, 1, 1, 0, 4'b0001);

        // ---- apply ----
        drive(1'b1, 4'b0, 4'b0, 4'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].valid, vecs[i].first, vecs[i].last,
                  vecs[i].pl, vecs[i].rtx);
            #1;
            check($sformatf("%s[%0d]", vecs[i].name, i), sample(), vecs[i].exp);
        end

        // ---- fairness: all ports always offer single-beat packets ----
        @(negedge clk);
        drive(1'b1, 4'b0, 4'b0, 4'b0, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            p = k % N;
            waited = 0;
            while (waited <= 4) begin
                @(negedge clk);
                drive(1'b0, 4'b1111, 4'b1111, 4'b1111, 8'(k), 1'b1);
                #1;
                if (bus.grant_valid) break;
                waited++;
            end
            check($sformatf("fair_bubble%0d", k), 64'(waited), 64'd1);
            check($sformatf("fair_pkt%0d", k), sample(),
                  pack(1'b1, 1'b1, 1'b1, 1'b1, 2'(p), onehot(p), pl_of(p, 8'(k))));
        end

        @(negedge clk);
        drive(1'b0, 4'b0, 4'b0, 4'b0, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
